hazard_forward_ctrl: RTL
========================

# hazard_forward_ctrl

Parametrised hazard and forwarding controller for the MIPS pipeline. It tracks the destination registers of in-flight instructions in an internal shift register, one entry per stage from EX onward. From these entries it produces registered operand-forward selects for the instruction entering EX, a load-use stall, and bubble insertion. Successor to the fixed two-source forwarding logic: it generalises to N forwarding stages and configurable load latency, and adds hold, flush and stall accounting.

## Interface
- REG_AW, 5, register address width
- DEPTH, 3, tracked stages after ID (entry 0 = EX … entry DEPTH-1 = last writing stage); ≥2
- LOAD_STAGE, 1, first entry index at which a load result is forwardable
- CNT_W, 16, stall counter width
- FW (localparam), clog2(DEPTH), forward-select width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs, id_rt  in  REG_AW  source registers of ID instruction
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_rd  in  REG_AW  destination of ID instruction
- id_we  in  1  ID instruction writes id_rd
- id_is_load  in  1  ID instruction is a load
- flush  in  1  kill ID instruction (taken branch/jump)
- ex_hold  in  1  global freeze (memory wait)
- fwd_a, fwd_b  out  FW  registered select for EX operand A (rs) / B (rt); 0 = register file, k = result of entry k-1
- stall  out  1  combinational; hold PC and IF/ID
- bubble  out  1  registered; instruction now in EX is an inserted bubble
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Each entry holds {v, rd, ld}. An entry is a write candidate iff v=1 and rd≠0; register 0 is never forwarded.
- Match for a source s (rs or rt, only when id_uses_s=1): the lowest index i in 0..DEPTH-2 with candidate entry[i].rd == s. The youngest match wins. Entry DEPTH-1 is never matched because the register file is write-through.
- hazard = id_valid & ~flush & (some used source has its youngest match at i < LOAD_STAGE with entry[i].ld=1).
- stall = hazard & ~ex_hold.
- Advance, on a rising edge with ex_hold=0:
  - entry[i+1] ← entry[i] for all i.
  - entry[0] ← {id_valid & ~flush & ~hazard & id_we, id_rd, id_is_load}.
  - fwd_a/fwd_b ← (match index + 1), or 0 if there is no match, the source is unused, or the slot is a bubble/flush.
  - bubble ← hazard | flush | ~id_valid.
  - stall_cnt increments when hazard=1 and saturates at all-ones.
- ex_hold=1: every register holds its value, including fwd_a, fwd_b, bubble and stall_cnt. stall is forced to 0 because the whole pipe is frozen.
- Simultaneous flush and hazard: flush wins. The bubble is inserted, stall=0, and stall_cnt is unchanged.
- Multi-cycle load latency (LOAD_STAGE>1) is handled naturally: stall stays high until the load reaches entry LOAD_STAGE.

## Timing
- Reset (asynchronous, immediate): all entries invalid, fwd_a=fwd_b=0, bubble=1, stall_cnt=0. stall=0 follows from the invalid entries.
- stall is combinational from the ID inputs and entry state, within the same cycle.
- fwd_a, fwd_b and bubble are valid in the cycle the instruction occupies EX: one cycle after it was in ID. They are aligned with the ID/EX register.
- Load-use with LOAD_STAGE=1: exactly 1 stall cycle for a back-to-back use; 0 stall cycles with one instruction in between.
- Reset asserted mid-stall: stall drops immediately, and all in-flight tracking is discarded.

## Test plan
(DEPTH=3, LOAD_STAGE=1 unless noted)
- add r3 then add r5,r3,r3 back-to-back → in the second instruction's EX cycle, fwd_a=1 and fwd_b=1, stall never asserted.
- add r3; add r3; use r3 → fwd=1 (youngest wins). With a non-writing instruction in between instead → fwd=2. Writer with rd=0 → fwd=0.
- lw r4 then sub r6,r4,r1 → stall=1 for one cycle and stall_cnt=1. Next cycle bubble=1 in EX. The sub reaches EX with fwd_a=2 and fwd_b=0. Same sequence with id_uses_rs=0 → no stall.
- lw r4 then use r4 with flush=1 in the hazard cycle → stall=0, bubble=1, stall_cnt unchanged. With ex_hold=1 during the hazard cycle → stall=0, all outputs frozen; the stall occurs after hold releases.
- DEPTH=4, LOAD_STAGE=2: lw r7 then immediate use → stall for 2 cycles, then fwd=3. Assert reset during the second stall cycle → stall=0 immediately, fwd_a=fwd_b=0, stall_cnt=0.
- CNT_W=4: 20 consecutive load-use stalls → stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage request and EX-stage forwarding result bundle for hazard_forward_ctrl.
// master: pipeline side that presents the ID instruction and consumes selects.
// slave:  the hazard/forwarding controller.
interface hazard_forward_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned FW = $clog2(DEPTH);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              flush;
    logic              ex_hold;

    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;
    logic              stall;
    logic              bubble;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_we, id_is_load, flush, ex_hold,
        input  fwd_a, fwd_b, stall, bubble, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_we, id_is_load, flush, ex_hold,
        output fwd_a, fwd_b, stall, bubble, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: tracks destinations of in-flight
// instructions (entry 0 = EX ... entry DEPTH-1 = last writer), produces
// registered operand-forward selects, a combinational load-use stall,
// bubble marking and a saturating stall counter.
module hazard_forward_ctrl #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_forward_ctrl_if.slave bus
);
    localparam int unsigned FW = $clog2(DEPTH);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent0_d;
    logic [FW-1:0]     fwd_a_q, fwd_a_d;
    logic [FW-1:0]     fwd_b_q, fwd_b_d;
    logic              bubble_q, bubble_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              hit_a, hit_b;
    logic              ld_a, ld_b;
    logic [FW-1:0]     sel_a, sel_b;
    logic              hazard;
    logic              kill;

    // Youngest-match search; scanning oldest-to-youngest lets the youngest
    // writer overwrite. Loop index i is the select value (entry i-1), and the
    // last entry is skipped because the register file writes through.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = DEPTH - 1; i > 0; i--) begin
            if (ent_q[i-1].v && (ent_q[i-1].rd != '0) && (ent_q[i-1].rd == bus.id_rs)) begin
                hit_a = 1'b1;
                sel_a = FW'(i);
                ld_a  = ent_q[i-1].ld && ((i - 1) < LOAD_STAGE);
            end
            if (ent_q[i-1].v && (ent_q[i-1].rd != '0) && (ent_q[i-1].rd == bus.id_rt)) begin
                hit_b = 1'b1;
                sel_b = FW'(i);
                ld_b  = ent_q[i-1].ld && ((i - 1) < LOAD_STAGE);
            end
        end
    end

    // Hazard decision and next-state values for the ID/EX-aligned registers.
    always_comb begin
        hazard    = bus.id_valid && !bus.flush &&
                    ((bus.id_uses_rs && hit_a && ld_a) ||
                     (bus.id_uses_rt && hit_b && ld_b));
        kill      = !bus.id_valid || bus.flush || hazard;
        ent0_d    = '{v:  bus.id_valid && !bus.flush && !hazard && bus.id_we,
                      rd: bus.id_rd,
                      ld: bus.id_is_load};
        fwd_a_d   = (kill || !bus.id_uses_rs) ? '0 : sel_a;
        fwd_b_d   = (kill || !bus.id_uses_rt) ? '0 : sel_b;
        bubble_d  = kill;
        cnt_d     = (hazard && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Pipeline tracking state; everything freezes while ex_hold is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            fwd_a_q  <= '0;
            fwd_b_q  <= '0;
            bubble_q <= 1'b1;
            cnt_q    <= '0;
        end else if (!bus.ex_hold) begin
            ent_q[0] <= ent0_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                ent_q[i] <= ent_q[i-1];
            end
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            bubble_q <= bubble_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.stall     = hazard && !bus.ex_hold;
    assign bus.fwd_a     = fwd_a_q;
    assign bus.fwd_b     = fwd_b_q;
    assign bus.bubble    = bubble_q;
    assign bus.stall_cnt = cnt_q;
endmodule
